// File: rtl/pll_phase_shift_sequencer.sv
// pll_phase_shift_sequencer
// Shares the PLL fine-phase-shift port between NUM_REQ requesters. Move
// requests are granted round-robin and executed one PLL step at a time:
// strobe, wait for done (with timeout), settle, repeat. The absolute fine
// phase offset of the shifted outputs is tracked modulo PHASE_STEPS.
//
// Ports
//   i_clk               sequencer clock (also the PLL phase_shift_clk)
//   i_rst               synchronous active-high reset
//   i_pll_lock          PLL locked
//   i_req_valid[N]      per-requester move request (level)
//   i_req_inc[N]        per-requester direction, 1 = advance
//   i_req_steps[N*SW]   per-requester step count, requester i at [i*SW +: SW]
//   o_req_ready[N]      one-hot accept pulse
//   o_req_done[N]       one-hot completion pulse
//   o_req_error[N]      pulse with o_req_done when the request aborted
//   o_phase_shift_en    one-cycle step strobe to the PLL
//   o_phase_shift_inc   step direction to the PLL
//   i_phase_shift_done  step complete from the PLL
//   o_phase_offset      current offset, 0..PHASE_STEPS-1
//   o_busy              sequencer not idle
module pll_phase_shift_sequencer #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned STEP_WIDTH     = 8,
    parameter int unsigned PHASE_STEPS    = 112,
    parameter int unsigned PHASE_WIDTH    = 7,
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_pll_lock,
    input  logic [NUM_REQ-1:0]             i_req_valid,
    input  logic [NUM_REQ-1:0]             i_req_inc,
    input  logic [NUM_REQ*STEP_WIDTH-1:0]  i_req_steps,
    output logic [NUM_REQ-1:0]             o_req_ready,
    output logic [NUM_REQ-1:0]             o_req_done,
    output logic [NUM_REQ-1:0]             o_req_error,
    output logic                           o_phase_shift_en,
    output logic                           o_phase_shift_inc,
    input  logic                           i_phase_shift_done,
    output logic [PHASE_WIDTH-1:0]         o_phase_offset,
    output logic                           o_busy
);

    localparam int unsigned IDX_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TMO_W       = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned SETTLE_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned PHASE_LAST  = PHASE_STEPS - 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_SETTLE,
        ST_COMPLETE
    } state_t;

    state_t                  r_state;
    logic [IDX_W-1:0]        r_last;
    logic [IDX_W-1:0]        r_gnt;
    logic                    r_inc;
    logic [STEP_WIDTH-1:0]   r_rem;
    logic [TMO_W-1:0]        r_tmo;
    logic [SETTLE_W-1:0]     r_settle;
    logic [PHASE_WIDTH-1:0]  r_offset;
    logic [NUM_REQ-1:0]      r_ready;
    logic [NUM_REQ-1:0]      r_done;
    logic [NUM_REQ-1:0]      r_err;
    logic                    r_en;
    logic                    r_ps_inc;
    logic                    r_busy;

    logic                    w_gnt_valid;
    logic [IDX_W-1:0]        w_gnt_idx;
    logic                    w_gnt_inc;
    logic [STEP_WIDTH-1:0]   w_gnt_steps;
    logic [NUM_REQ-1:0]      w_gnt_onehot;
    logic [NUM_REQ-1:0]      w_cur_onehot;
    logic [PHASE_WIDTH-1:0]  w_off_inc;
    logic [PHASE_WIDTH-1:0]  w_off_dec;

    // Requester index k positions after the last grant.
    function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] last, input int k);
        rr_index = IDX_W'((int'(last) + 1 + k) % int'(NUM_REQ));
    endfunction

    // Round-robin pick: scan from the farthest candidate back so the nearest wins.
    always_comb begin
        w_gnt_valid = 1'b0;
        w_gnt_idx   = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (i_req_valid[rr_index(r_last, k)]) begin
                w_gnt_valid = 1'b1;
                w_gnt_idx   = rr_index(r_last, k);
            end
        end
    end

    assign w_gnt_inc    = i_req_inc[w_gnt_idx];
    assign w_gnt_steps  = i_req_steps[32'(w_gnt_idx) * STEP_WIDTH +: STEP_WIDTH];
    assign w_gnt_onehot = NUM_REQ'(1) << w_gnt_idx;
    assign w_cur_onehot = NUM_REQ'(1) << r_gnt;

    // Offset wraps modulo one output period in both directions.
    assign w_off_inc = (r_offset == PHASE_WIDTH'(PHASE_LAST)) ? '0 : r_offset + 1'b1;
    assign w_off_dec = (r_offset == '0) ? PHASE_WIDTH'(PHASE_LAST) : r_offset - 1'b1;

    // Sequencer FSM with registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= ST_IDLE;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_gnt    <= '0;
            r_inc    <= 1'b0;
            r_rem    <= '0;
            r_tmo    <= '0;
            r_settle <= '0;
            r_offset <= '0;
            r_ready  <= '0;
            r_done   <= '0;
            r_err    <= '0;
            r_en     <= 1'b0;
            r_ps_inc <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_ready <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_en    <= 1'b0;

            if (!i_pll_lock) begin
                // PLL restarts at its default phase; any in-flight request aborts.
                r_offset <= '0;
                if (r_state != ST_IDLE) begin
                    r_done  <= w_cur_onehot;
                    r_err   <= w_cur_onehot;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_gnt_valid) begin
                            r_ready <= w_gnt_onehot;
                            r_gnt   <= w_gnt_idx;
                            r_last  <= w_gnt_idx;
                            r_inc   <= w_gnt_inc;
                            r_rem   <= w_gnt_steps;
                            r_busy  <= 1'b1;
                            r_state <= (w_gnt_steps == '0) ? ST_COMPLETE : ST_ISSUE;
                        end
                    end

                    ST_ISSUE: begin
                        r_en     <= 1'b1;
                        r_ps_inc <= r_inc;
                        r_tmo    <= '0;
                        r_state  <= ST_WAIT;
                    end

                    ST_WAIT: begin
                        // done wins over a coincident timeout.
                        if (i_phase_shift_done) begin
                            r_offset <= r_inc ? w_off_inc : w_off_dec;
                            r_rem    <= r_rem - 1'b1;
                            r_settle <= '0;
                            if (r_rem == STEP_WIDTH'(1)) begin
                                r_state <= ST_COMPLETE;
                            end else if (SETTLE_CYCLES == 0) begin
                                r_state <= ST_ISSUE;
                            end else begin
                                r_state <= ST_SETTLE;
                            end
                        end else if (r_tmo == TMO_W'(TIMEOUT_CYCLES)) begin
                            r_done  <= w_cur_onehot;
                            r_err   <= w_cur_onehot;
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_tmo <= r_tmo + 1'b1;
                        end
                    end

                    ST_SETTLE: begin
                        if (r_settle == SETTLE_W'(SETTLE_LAST)) begin
                            r_state <= ST_ISSUE;
                        end else begin
                            r_settle <= r_settle + 1'b1;
                        end
                    end

                    ST_COMPLETE: begin
                        r_done  <= w_cur_onehot;
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end

                    default: begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_req_ready       = r_ready;
    assign o_req_done        = r_done;
    assign o_req_error       = r_err;
    assign o_phase_shift_en  = r_en;
    assign o_phase_shift_inc = r_ps_inc;
    assign o_phase_offset    = r_offset;
    assign o_busy            = r_busy;

endmodule

// File: doc/pll_phase_shift_sequencer.md
Name: pll_phase_shift_sequencer

Overview:
Owns the PLL fine-phase-shift port (phase_shift_en/inc/done) of the oversampling clock PLL and shares it between NUM_REQ requesters, e.g. the initial phase alignment FSM and a runtime eye-tracking loop. It accepts multi-step move requests and arbitrates between them round-robin. It issues one PLL step at a time with done-handshake, settle delay and timeout. It maintains the absolute fine-phase offset of the shifted outputs, modulo one output period.

Parameters:
NUM_REQ, 2, number of requesters
STEP_WIDTH, 8, width of per-request step count
PHASE_STEPS, 112, fine steps per 625 MHz output period (VCO/56 granularity, VCO = 2x output)
PHASE_WIDTH, 7, width of phase_offset; must satisfy 2^PHASE_WIDTH >= PHASE_STEPS
SETTLE_CYCLES, 16, idle cycles between consecutive steps of one request (0 allowed)
TIMEOUT_CYCLES, 255, max cycles waiting for phase_shift_done per step

Ports:
clk  in  1  sequencer clock; also drives the PLL phase_shift_clk
rst  in  1  synchronous active-high reset
pll_lock  in  1  PLL locked
req_valid  in  NUM_REQ  per-requester move request, level
req_inc  in  NUM_REQ  direction per requester: 1 = advance, 0 = retard
req_steps  in  NUM_REQ*STEP_WIDTH  step count per requester; requester i uses bits [i*STEP_WIDTH +: STEP_WIDTH]
req_ready  out  NUM_REQ  one-hot 1-cycle accept pulse
req_done  out  NUM_REQ  one-hot 1-cycle completion pulse
req_error  out  NUM_REQ  1-cycle pulse, coincident with req_done, when the request aborted
phase_shift_en  out  1  to PLL, 1-cycle step strobe
phase_shift_inc  out  1  to PLL, direction; valid while phase_shift_en is high
phase_shift_done  in  1  from PLL, step complete
phase_offset  out  PHASE_WIDTH  current offset, 0..PHASE_STEPS-1
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer selects requester 0 first.
- States: IDLE, ISSUE, WAIT, SETTLE, COMPLETE.
- IDLE, arbitration:
  - Arbitrates only when pll_lock=1.
  - Grants the first asserted req_valid at or after (last_grant+1) mod NUM_REQ.
  - In the grant cycle: req_ready[g] pulses; inc and steps for the grantee are latched; last_grant is updated.
  - Requester inputs are ignored after latch.
  - Requester must drop req_valid after req_ready, or it is re-arbitrated later.
- Zero-step request:
  - steps=0 goes to COMPLETE.
  - req_done pulses the cycle after req_ready; no PLL strobe.
- ISSUE:
  - phase_shift_en=1 and phase_shift_inc=latched inc for exactly one cycle.
  - The strobe is in the cycle after req_ready (or after SETTLE ends).
  - Then WAIT, with the timeout counter cleared.
- WAIT:
  - phase_shift_done is sampled only in WAIT; done in other states is ignored.
  - On done, phase_offset updates the next cycle: inc gives PHASE_STEPS-1 -> 0, dec gives 0 -> PHASE_STEPS-1, otherwise ±1.
  - On done the remaining count decrements. If it reaches 0, go to COMPLETE; else go to SETTLE, or to ISSUE if SETTLE_CYCLES=0.
  - If the counter reaches TIMEOUT_CYCLES without done: abort, with no offset update for that step.
- SETTLE: counts SETTLE_CYCLES cycles, then ISSUE.
- COMPLETE: req_done[g] pulses for one cycle; next state IDLE.
  - Earliest next grant is the cycle after COMPLETE.
- Abort:
  - Caused by a timeout, or by pll_lock=0 in any non-IDLE state.
  - In the next cycle, req_done[g] and req_error[g] pulse together, then IDLE.
  - Steps already completed stay reflected in phase_offset.
- Lock loss:
  - pll_lock=0, in any state, sets phase_offset to 0 the next cycle, because the PLL restarts at its default phase.
  - Lock loss mid-request also aborts as above.
- Simultaneous events: a done and a timeout in the same WAIT cycle count as done.
- rst mid-operation:
  - Returns to IDLE immediately, with outputs per reset values.
  - No req_done is issued for the in-flight request.
- Strobe rate: at most one phase_shift_en per done.
  - A new strobe never occurs while a step is outstanding.

Test Plan:
- Move with settle: reset, pll_lock=1, req0 inc steps=3 -> req_ready[0] 1 cycle; 3 en pulses with inc=1, each ≥16 cycles after the previous done; phase_offset 0->3; req_done[0] once, req_error=0.
- Wrap-around: from offset 0, req1 dec steps=1 -> phase_offset=111. Then req1 inc steps=2 -> phase_offset=1.
- Round-robin: both req_valid held, steps=1 each, starting after reset -> grant order 0,1,0,1; never two consecutive grants to the same requester while the other is pending.
- Timeout: PLL model never returns done on the 2nd of 4 steps -> req_done and req_error pulse 256 cycles after the 2nd en; phase_offset advanced by exactly 1; next request serviced normally.
- Lock loss: drop pll_lock during WAIT of a 5-step request -> abort pulse with error the next cycle; phase_offset=0; no grants until pll_lock=1.
- Edge cases: a steps=0 request -> req_done the cycle after req_ready, no en. Spurious done in IDLE -> no offset change. rst in SETTLE -> all outputs 0 and no req_done.
